// File: rtl/soc_apb_pkg.sv
// Shared definitions for the APB initiator: FSM state encoding, APB data
// width and the default ACCESS timeout limit.
package soc_apb_pkg;

    localparam int unsigned APB_DW                 = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage : soc_apb_pkg

// File: rtl/soc_apb_initiator.sv
// Single-outstanding APB3 initiator. Turns a valid/ready load/store request
// into one SETUP + ACCESS transfer and returns a one-cycle response pulse.
// At least two idle APB cycles (RESP + IDLE) separate consecutive transfers.
// Optional build macro SOC_APB_INIT_TIMEOUT_EN adds an 8-bit ACCESS timeout
// that aborts a transfer with resp_err=1 after TIMEOUT_CYCLES wait cycles.
module soc_apb_initiator
    import soc_apb_pkg::*;
#(
    parameter int unsigned W_ADDR         = 32,
    parameter int unsigned W_PADDR        = 16,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    // request side
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [W_ADDR-1:0]  req_addr,
    input  logic [APB_DW-1:0]  req_wdata,
    // response side
    output logic               resp_valid,
    output logic [APB_DW-1:0]  resp_rdata,
    output logic               resp_err,
    // APB side
    output logic [W_PADDR-1:0] paddr,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [APB_DW-1:0]  pwdata,
    input  logic [APB_DW-1:0]  prdata,
    input  logic               pready,
    input  logic               pslverr
);

    apb_state_e state;

    // Upper address bits belong to the fabric decoder; the low two bits are
    // dropped because APB transfers are always word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[W_ADDR-1:W_PADDR], req_addr[1:0]};

`ifdef SOC_APB_INIT_TIMEOUT_EN
    // Counter value on the last permitted wait cycle: one more pready=0
    // cycle makes it reach TIMEOUT_CYCLES.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Transfer FSM with every output registered.
    // NOTE: all state and outputs, including the data registers, are reset
    // asynchronously so psel/penable drop the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
`ifdef SOC_APB_INIT_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments only; the default below is
            // overridden later in the same block to form the one-cycle pulse.
            resp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        pwrite    <= req_write;
                        paddr     <= {req_addr[W_PADDR-1:2], 2'b00};
                        pwdata    <= req_wdata;
                        state     <= ST_SETUP;
`ifdef SOC_APB_INIT_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        resp_rdata <= pwrite ? '0 : prdata;
                        resp_err   <= pslverr;
                        resp_valid <= 1'b1;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        state      <= ST_RESP;
                    end
`ifdef SOC_APB_INIT_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        state      <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
`endif
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : soc_apb_initiator

// File: tb/tb_soc_apb_initiator.sv
// Self-checking bench for soc_apb_initiator. A behavioural peripheral model
// answers APB transfers; expected responses come from a word-indexed
// reference memory updated from the request side. Build with
// SOC_APB_INIT_TIMEOUT_EN to also exercise the ACCESS timeout (limit 4).
module tb_soc_apb_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write;
    logic        req_ready;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fall_cyc = -1;

    // peripheral-side storage keyed by APB byte address
    logic [31:0] resp_mem [logic [15:0]];
    // reference storage keyed by word index, updated from requests
    logic [31:0] ref_mem [int];

    soc_apb_initiator #(
        .W_ADDR        (32),
        .W_PADDR       (16),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] periph_read(input logic [15:0] a);
        if (resp_mem.exists(a)) return resp_mem[a];
        return {16'hA5A5, a};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int w;
        w = int'(a[15:2]);
        if (ref_mem.exists(w)) return ref_mem[w];
        return {16'hA5A5, a[15:2], 2'b00};
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        resp_mem[{a[15:2], 2'b00}] = d;
        ref_mem[int'(a[15:2])]     = d;
    endtask

    // One complete request; called at a negedge, returns at the negedge of
    // the cycle after the response pulse (req_ready expected high again).
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input bit slverr, input bit hold);
        logic [15:0] exp_paddr;
        logic [31:0] exp_rdata;
        int n;
        exp_paddr = {addr[15:2], 2'b00};
        exp_rdata = wr ? 32'd0 : ref_read(addr);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(n < 20), 32'd1);
        if (n >= 20) begin
            req_valid = 1'b0;
            return;
        end
        // SETUP cycle
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        if (fall_cyc >= 0) check("psel_gap_ge2", 32'((cyc - fall_cyc) >= 2), 32'd1);
        check("setup_psel", 32'(psel), 32'd1);
        check("setup_penable", 32'(penable), 32'd0);
        check("setup_req_ready", 32'(req_ready), 32'd0);
        check("setup_paddr", 32'(paddr), 32'(exp_paddr));
        check("setup_pwrite", 32'(pwrite), 32'(wr));
        check("setup_pwdata", pwdata, wdata);
        // junk on responder inputs outside ACCESS must be ignored
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = $urandom;
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            check("access_psel", 32'(psel), 32'd1);
            check("access_penable", 32'(penable), 32'd1);
            check("access_paddr", 32'(paddr), 32'(exp_paddr));
            check("access_pwrite", 32'(pwrite), 32'(wr));
            check("access_pwdata", pwdata, wdata);
            check("access_no_resp", 32'(resp_valid), 32'd0);
            if (k == waits) begin
                pready  = 1'b1;
                pslverr = slverr;
                prdata  = pwrite ? $urandom : periph_read(paddr);
                if (pwrite && !slverr) resp_mem[paddr] = pwdata;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
        end
        // RESP cycle
        @(negedge clk);
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", 32'(resp_err), 32'(slverr));
        check("resp_psel_low", 32'(psel), 32'd0);
        check("resp_penable_low", 32'(penable), 32'd0);
        check("resp_req_ready", 32'(req_ready), 32'd0);
        fall_cyc = cyc;
        if (wr && !slverr) ref_mem[int'(addr[15:2])] = wdata;
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = $urandom;
        // back in IDLE
        @(negedge clk);
        check("idle_resp_pulse_end", 32'(resp_valid), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_psel_low", 32'(psel), 32'd0);
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // zero-wait read
        preload(32'h0000_0008, 32'h1234_5678);
        txn(1'b0, 32'h0000_0008, 32'h0, 0, 1'b0, 1'b0);

        // write with 3 wait states, then read it back
        txn(1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
        txn(1'b0, 32'h0000_0014, 32'h0, 1, 1'b0, 1'b0);

        // read with slave error: data still returned
        preload(32'h0000_0020, 32'hCAFE_F00D);
        txn(1'b0, 32'h0000_0020, 32'h0, 2, 1'b1, 1'b0);

        // req_valid held high across two timer requests
        preload(32'h0200_4000, 32'h0000_1111);
        txn(1'b1, 32'h0200_4004, 32'h0000_2222, 0, 1'b0, 1'b1);
        txn(1'b0, 32'h0200_4000, 32'h0, 0, 1'b0, 1'b0);

        // randomized traffic, upper address bits random
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            a = $urandom;
            a[15:5] = 11'($urandom_range(0, 3));
            txn(1'($urandom), a, $urandom, $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), 1'($urandom));
        end
        req_valid = 1'b0;

        // reset asserted during ACCESS
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0200_BFF8;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_accept", 32'(n < 20), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        pready    = 1'b0;
        @(negedge clk);
        check("rstmid_in_access", 32'(penable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_psel_async", 32'(psel), 32'd0);
        check("rstmid_penable_async", 32'(penable), 32'd0);
        check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_ready_next", 32'(req_ready), 32'd1);
        pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("rstmid_no_stray_resp", 32'(resp_valid), 32'd0);
            check("rstmid_no_psel", 32'(psel), 32'd0);
            @(negedge clk);
        end
        pready   = 1'b0;
        fall_cyc = -1;

`ifdef SOC_APB_INIT_TIMEOUT_EN
        // timeout: pready never arrives, limit 4
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0200_0000;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("to_accept", 32'(n < 20), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("to_setup", 32'(psel & ~penable), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("to_access_penable", 32'(penable), 32'd1);
            check("to_access_no_resp", 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        check("to_resp_valid", 32'(resp_valid), 32'd1);
        check("to_resp_err", 32'(resp_err), 32'd1);
        check("to_resp_rdata", resp_rdata, 32'd0);
        check("to_psel_low", 32'(psel), 32'd0);
        pready = 1'b1;
        prdata = 32'h5555_AAAA;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("to_late_pready_ignored", 32'(resp_valid), 32'd0);
        end
        pready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_soc_apb_initiator
